// File: rtl/blackjack_pkg.sv
// Shared definitions for the blackjack timing blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package blackjack_pkg;

    // Default sizing of the shared two-second timer arbiter
    localparam int N_REQ_DEF = 4;
    localparam int WIDTH_DEF = 12;

    // Timer-ownership states; encoding is fixed so debug taps read the same everywhere
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    // Index that follows idx in a ring of n requesters
    function automatic int ring_next(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or after the pointer, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to latch the pick.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_Req,
    input  logic [IW-1:0] i_Ptr,
    output logic [N-1:0]  o_Grant,
    output logic [IW-1:0] o_Index,
    output logic          o_Valid
);

    // Scan from farthest to nearest so the nearest set bit at/after the pointer wins
    always_comb begin
        o_Grant = '0;
        o_Index = '0;
        o_Valid = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            int j;
            j = (int'(i_Ptr) + k) % N;
            if (i_Req[j]) begin
                o_Grant    = '0;
                o_Grant[j] = 1'b1;
                o_Index    = IW'(j);
                o_Valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/delay_arbiter.sv
// Shares one two-second Counter among N_REQ requesters, round-robin, with a run watchdog.
// Latency: grant to done = 1 clear cycle + run cycles until i_TwoSec + 1 done cycle.
// Backpressure: requests are level-held; losers wait while the timer is owned, never dropped.
module delay_arbiter
    import blackjack_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int TIMEOUT = 2**WIDTH + 8
) (
    input  logic             clk_2K,
    input  logic             i_Reset,
    input  logic [N_REQ-1:0] i_Req,
    input  logic             i_TwoSec,
    input  logic             i_ClrError,
    output logic             o_ActCounter,
    output logic             o_RstCounter,
    output logic [N_REQ-1:0] o_Grant,
    output logic [N_REQ-1:0] o_Done,
    output logic             o_Busy,
    output logic             o_Error
);

    localparam int IW  = $clog2(N_REQ);
    localparam int WDW = $clog2(TIMEOUT + 1);

    arb_state_t       r_State;
    arb_state_t       w_NextState;
    logic [N_REQ-1:0] r_Grant;
    logic [IW-1:0]    r_GrantIdx;
    logic [IW-1:0]    r_Ptr;
    logic [WDW-1:0]   r_Wdog;
    logic             r_Error;

    logic [N_REQ-1:0] w_ArbGrant;
    logic [IW-1:0]    w_ArbIdx;
    logic             w_ArbValid;
    logic             w_OwnerReq;
    logic             w_PtrAdv;
    logic             w_WdogFire;
    logic [IW-1:0]    w_PtrAfterOwner;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr (
        .i_Req   (i_Req),
        .i_Ptr   (r_Ptr),
        .o_Grant (w_ArbGrant),
        .o_Index (w_ArbIdx),
        .o_Valid (w_ArbValid)
    );

    assign w_OwnerReq      = |(i_Req & r_Grant);
    assign w_PtrAfterOwner = IW'(ring_next(int'(r_GrantIdx), N_REQ));

    // State register
    always_ff @(posedge clk_2K or posedge i_Reset) begin
        if (i_Reset) begin
            r_State <= IDLE;
        end else begin
            r_State <= w_NextState;
        end
    end

    // Next state and counter controls; abort beats expiry beats watchdog in RUN
    always_comb begin
        w_NextState  = r_State;
        o_ActCounter = 1'b0;
        o_RstCounter = 1'b0;
        o_Done       = '0;
        w_PtrAdv     = 1'b0;
        w_WdogFire   = 1'b0;
        case (r_State)
            IDLE: begin
                if (w_ArbValid) begin
                    w_NextState = CLEAR;
                end
            end
            CLEAR: begin
                o_RstCounter = 1'b1;
                w_NextState  = RUN;
            end
            RUN: begin
                o_ActCounter = 1'b1;
                if (!w_OwnerReq) begin
                    w_NextState = IDLE;
                    w_PtrAdv    = 1'b1;
                end else if (i_TwoSec) begin
                    w_NextState = DONE;
                end else if (r_Wdog == WDW'(TIMEOUT - 1)) begin
                    w_WdogFire  = 1'b1;
                    w_NextState = IDLE;
                    w_PtrAdv    = 1'b1;
                end
            end
            DONE: begin
                o_Done       = r_Grant;
                o_RstCounter = 1'b1;
                w_PtrAdv     = 1'b1;
                w_NextState  = IDLE;
            end
            default: begin
                w_NextState = IDLE;
            end
        endcase
    end

    // Owner latch and round-robin pointer
    always_ff @(posedge clk_2K or posedge i_Reset) begin
        if (i_Reset) begin
            r_Grant    <= '0;
            r_GrantIdx <= '0;
            r_Ptr      <= '0;
        end else begin
            if (r_State == IDLE && w_ArbValid) begin
                r_Grant    <= w_ArbGrant;
                r_GrantIdx <= w_ArbIdx;
            end
            if (w_PtrAdv) begin
                r_Ptr <= w_PtrAfterOwner;
            end
        end
    end

    // Watchdog counts owned RUN cycles from a fresh clear
    always_ff @(posedge clk_2K or posedge i_Reset) begin
        if (i_Reset) begin
            r_Wdog <= '0;
        end else if (r_State == CLEAR) begin
            r_Wdog <= '0;
        end else if (r_State == RUN) begin
            r_Wdog <= r_Wdog + 1'b1;
        end
    end

    // Sticky error; a fire in the same cycle as a clear keeps it set
    always_ff @(posedge clk_2K or posedge i_Reset) begin
        if (i_Reset) begin
            r_Error <= 1'b0;
        end else if (w_WdogFire) begin
            r_Error <= 1'b1;
        end else if (i_ClrError) begin
            r_Error <= 1'b0;
        end
    end

    assign o_Grant = (r_State == IDLE) ? '0 : r_Grant;
    assign o_Busy  = (r_State != IDLE);
    assign o_Error = r_Error;

endmodule

// File: tb/tb_delay_arbiter.sv
module tb_delay_arbiter;

    localparam int NR  = 4;
    localparam int W   = 4;
    localparam int TO  = 24;
    localparam int EXP = (1 << W) - 1;

    logic          clk_2K = 1'b0;
    logic          i_Reset = 1'b1;
    logic [NR-1:0] i_Req = '0;
    logic          i_TwoSec;
    logic          i_ClrError = 1'b0;
    logic          o_ActCounter, o_RstCounter, o_Busy, o_Error;
    logic [NR-1:0] o_Grant, o_Done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_2K = ~clk_2K;

    delay_arbiter #(.N_REQ(NR), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk_2K       (clk_2K),
        .i_Reset      (i_Reset),
        .i_Req        (i_Req),
        .i_TwoSec     (i_TwoSec),
        .i_ClrError   (i_ClrError),
        .o_ActCounter (o_ActCounter),
        .o_RstCounter (o_RstCounter),
        .o_Grant      (o_Grant),
        .o_Done       (o_Done),
        .o_Busy       (o_Busy),
        .o_Error      (o_Error)
    );

    // Attached Counter: flags the active cycle on which the count reaches 2**W-1
    logic [W-1:0] r_cnt;
    logic         tie0 = 1'b0;
    always @(posedge clk_2K or posedge i_Reset) begin
        if (i_Reset)           r_cnt <= '0;
        else if (o_RstCounter) r_cnt <= '0;
        else if (o_ActCounter) r_cnt <= r_cnt + 1'b1;
    end
    assign i_TwoSec = !tie0 && o_ActCounter && (r_cnt == W'(EXP - 1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: owner (-1 idle), age since grant (0 = clear cycle, k = k-th run cycle)
    int m_owner = -1;
    int m_age   = 0;
    bit m_fin   = 0;
    int m_ptr   = 0;
    bit m_err   = 0;

    function automatic int pick(input logic [NR-1:0] r, input int p);
        for (int k = 0; k < NR; k++) if (r[(p + k) % NR]) return (p + k) % NR;
        return -1;
    endfunction

    always @(posedge clk_2K or posedge i_Reset) begin
        if (i_Reset) begin
            m_owner <= -1; m_age <= 0; m_fin <= 0; m_ptr <= 0; m_err <= 0;
        end else begin
            if (i_ClrError) m_err <= 0;
            if (m_owner < 0) begin
                if (i_Req != 0) begin
                    m_owner <= pick(i_Req, m_ptr); m_age <= 0; m_fin <= 0;
                end
            end else if (m_fin) begin
                m_ptr <= (m_owner + 1) % NR; m_owner <= -1; m_fin <= 0;
            end else if (m_age == 0) begin
                m_age <= 1;
            end else if (!i_Req[m_owner]) begin
                m_ptr <= (m_owner + 1) % NR; m_owner <= -1;
            end else if (!tie0 && m_age == EXP) begin
                m_fin <= 1;
            end else if (m_age == TO) begin
                m_err <= 1; m_ptr <= (m_owner + 1) % NR; m_owner <= -1;
            end else begin
                m_age <= m_age + 1;
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk_2K) begin
        logic [NR-1:0] eg;
        logic [2*NR+3:0] exp_v, act_v;
        eg    = (m_owner < 0) ? '0 : (NR'(1) << m_owner);
        exp_v = {eg, (m_fin ? eg : {NR{1'b0}}), (m_owner >= 0),
                 (m_owner >= 0 && m_age > 0 && !m_fin),
                 (m_owner >= 0 && (m_age == 0 || m_fin)), m_err};
        act_v = {o_Grant, o_Done, o_Busy, o_ActCounter, o_RstCounter, o_Error};
        chk("model_cycle{grant,done,busy,act,rst,err}", 32'(act_v), 32'(exp_v));
        chk("act_and_rst_exclusive", 32'(o_ActCounter & o_RstCounter), 0);
    end

    task automatic do_reset();
        @(posedge clk_2K); #1 i_Reset = 1'b1; i_Req = '0;
        @(negedge clk_2K);
        chk("reset_outputs", 32'({o_Grant, o_Done, o_Busy, o_ActCounter, o_RstCounter, o_Error}), 0);
        @(posedge clk_2K); #1 i_Reset = 1'b0;
    endtask

    task automatic wait_clear();
        bit seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk_2K);
            if (o_RstCounter && o_Done == 0) seen = 1;
        end
        chk("clear_seen", 32'(seen), 1);
    endtask

    // One ownership: clear, count run cycles, check the done pulse, optionally drop the request
    task automatic run_one(input logic [NR-1:0] eg, input bit drop);
        int n = 0;
        bit seen = 0;
        wait_clear();
        chk("grant_order", 32'(o_Grant), 32'(eg));
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk_2K);
            if (o_Done != 0) seen = 1;
            else if (o_ActCounter) n++;
        end
        chk("done_seen", 32'(seen), 1);
        chk("done_matches_grant", 32'(o_Done), 32'(eg));
        chk("run_length", 32'(n), 15);
        if (drop) i_Req = i_Req & ~eg;
        @(negedge clk_2K);
        chk("done_one_cycle", 32'(o_Done), 0);
    endtask

    initial begin
        int n;
        bit seen;
        repeat (2) @(negedge clk_2K);
        chk("reset_outputs_initial", 32'({o_Grant, o_Done, o_Busy, o_ActCounter, o_RstCounter, o_Error}), 0);
        @(posedge clk_2K); #1 i_Reset = 1'b0;

        // Single requester
        i_Req = 4'b0001;
        run_one(4'b0001, 1);
        chk("single_busy_after", 32'(o_Busy), 0);

        // Contention from reset
        do_reset();
        i_Req = 4'b1011;
        run_one(4'b0001, 1);
        run_one(4'b0010, 1);
        run_one(4'b1000, 1);

        // Fairness with two held requests
        do_reset();
        i_Req = 4'b0011;
        run_one(4'b0001, 0);
        run_one(4'b0010, 0);
        run_one(4'b0001, 0);
        i_Req = '0;
        repeat (3) @(negedge clk_2K);

        // Abort on run cycle 5; pointer must move past requester 2
        do_reset();
        i_Req = 4'b0100;
        wait_clear();
        chk("abort_grant", 32'(o_Grant), 32'h4);
        repeat (5) @(posedge clk_2K);
        #1 i_Req = '0;
        @(negedge clk_2K);
        chk("abort_run5_active", 32'(o_ActCounter), 1);
        @(negedge clk_2K);
        chk("abort_idle_busy", 32'(o_Busy), 0);
        chk("abort_no_done", 32'(o_Done), 0);
        i_Req = 4'b0101;
        run_one(4'b0001, 1);
        run_one(4'b0100, 1);

        // Watchdog with expiry never reported
        do_reset();
        tie0 = 1'b1;
        i_Req = 4'b0001;
        wait_clear();
        n = 0; seen = 0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk_2K);
            if (!o_Busy) seen = 1;
            else if (o_ActCounter) n++;
        end
        i_Req = '0;
        chk("wdog_idle_seen", 32'(seen), 1);
        chk("wdog_run_cycles", 32'(n), 24);
        chk("wdog_error_set", 32'(o_Error), 1);
        repeat (3) @(negedge clk_2K);
        chk("wdog_error_sticky", 32'(o_Error), 1);
        @(posedge clk_2K); #1 i_ClrError = 1'b1;
        @(posedge clk_2K); #1 i_ClrError = 1'b0;
        @(negedge clk_2K);
        chk("wdog_error_cleared", 32'(o_Error), 0);

        // Clear asserted in the firing cycle: set wins
        i_Req = 4'b0001;
        wait_clear();
        repeat (24) @(posedge clk_2K);
        #1 i_ClrError = 1'b1;
        @(posedge clk_2K); #1 i_ClrError = 1'b0; i_Req = '0;
        @(negedge clk_2K);
        chk("wdog_set_beats_clear", 32'(o_Error), 1);
        @(posedge clk_2K); #1 i_ClrError = 1'b1;
        @(posedge clk_2K); #1 i_ClrError = 1'b0;
        tie0 = 1'b0;

        // Reset in the middle of a run, then a clean full run
        do_reset();
        i_Req = 4'b0100;
        wait_clear();
        repeat (7) @(posedge clk_2K);
        #1 i_Reset = 1'b1;
        #1 chk("midrun_reset_async", 32'({o_Grant, o_Done, o_Busy, o_ActCounter, o_RstCounter, o_Error}), 0);
        @(negedge clk_2K);
        @(posedge clk_2K); #1 i_Reset = 1'b0;
        run_one(4'b0100, 1);
        repeat (3) @(negedge clk_2K);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the bench always ends
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
